mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the data word width.
REQ-002 Parameter ADDR_W, default 6, SHALL set the memory address width.
REQ-003 Parameter DEPTH, default 64, SHALL set the number of valid words, at addresses 0..DEPTH-1.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  SHALL be the synchronous, active-high reset.
REQ-006 req_valid  in  1  SHALL indicate that a request is presented.
REQ-007 req_ready  out  1  SHALL indicate that the unit accepts a request this cycle.
REQ-008 req_we  in  1  SHALL select the request type: 1 = store, 0 = load.
REQ-009 req_base  in  8  SHALL carry the unsigned base address.
REQ-010 req_offset  in  8  SHALL carry the two's-complement signed offset.
REQ-011 req_wdata  in  DATA_W  SHALL carry the store data.
REQ-012 resp_valid  out  1  SHALL indicate that a response is held.
REQ-013 resp_ready  in  1  SHALL indicate that the consumer takes the response.
REQ-014 resp_rdata  out  DATA_W  SHALL carry the load data (0 for stores and errors).
REQ-015 resp_err  out  1  SHALL flag an out-of-range address.
REQ-016 err_count  out  8  SHALL count errored requests, saturating.
REQ-017 mem_addr  out  ADDR_W  SHALL drive the address to data_memory.
REQ-018 mem_wdata  out  DATA_W  SHALL drive the write data to data_memory.
REQ-019 mem_read  out  1  SHALL be the read strobe to data_memory.
REQ-020 mem_write  out  1  SHALL be the write strobe to data_memory.
REQ-021 mem_rdata  in  DATA_W  SHALL receive data_memory's combinational read data.

Function
REQ-022 The FSM SHALL have exactly these states: IDLE, READ, WRITE, ERR, RESP.
REQ-023 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready are both 1 at a rising edge.
REQ-024 On acceptance, the effective address SHALL be computed as eff = zero-extend(req_base) + sign-extend(req_offset), using 10-bit signed arithmetic with no wrap.
REQ-025 Range routing on acceptance:
- eff < 0 or eff >= DEPTH: next state SHALL be ERR.
- Otherwise, req_we = 1: next state SHALL be WRITE.
- Otherwise, req_we = 0: next state SHALL be READ.
- In all three cases, eff[ADDR_W-1:0] and req_wdata SHALL be latched.
REQ-026 WRITE SHALL assert mem_write = 1 for exactly one cycle, with the latched mem_addr/mem_wdata, then go to RESP.
REQ-027 READ SHALL assert mem_read = 1 for exactly one cycle, with the latched mem_addr, capture mem_rdata into resp_rdata at the closing edge, then go to RESP.
REQ-028 ERR SHALL issue no memory strobe, set resp_err, increment err_count (saturating at 255), and go to RESP.
REQ-029 RESP SHALL hold resp_valid = 1 and the response fields stable until resp_ready = 1 at an edge; it SHALL then go to IDLE.
REQ-030 Latency: for a request accepted at edge 0, resp_valid SHALL be 1 from edge 2 for load, store and error alike.
REQ-031 Throughput: at most one request SHALL be outstanding; the next acceptance is possible at the edge after the response is taken.
REQ-032 mem_read and mem_write SHALL never both be 1, and both SHALL be 0 outside READ/WRITE.
REQ-033 mem_write SHALL be gated by !reset, so a reset asserted during the WRITE cycle cancels the write.
REQ-034 req_valid asserted while not in IDLE SHALL be ignored, with no side effects.
REQ-035 resp_rdata SHALL be 0 for store and error responses; resp_err SHALL be 0 for in-range responses.

Reset
REQ-036 When reset = 1 at an edge, the unit SHALL go to IDLE from any state, including mid-operation.
REQ-037 After reset: resp_valid = 0, resp_err = 0, resp_rdata = 0, err_count = 0, mem_addr = 0, mem_wdata = 0, mem_read = 0, mem_write = 0, req_ready = 1.
REQ-038 An in-flight response SHALL be discarded by reset and never presented.

Verification
REQ-039 Store base=10, offset=+5, wdata=0xBEEF -> one mem_write cycle at mem_addr = 15; response at edge 2 with resp_err = 0; a subsequent load from 15 returns 0xBEEF.
REQ-040 Load base=3, offset=-3 (0xFD) -> mem_addr = 0, mem_read pulsed once, resp_rdata = mem[0].
REQ-041 Boundary cases:
- base=63, offset=0 -> in range, mem_addr = 63.
- base=60, offset=+4 -> resp_err = 1, no strobe, err_count +1.
- base=0, offset=-1 -> resp_err = 1.
REQ-042 Hold resp_ready = 0 for 5 cycles -> resp_valid and the response fields stay stable; req_ready stays 0 and new requests are ignored.
REQ-043 Assert reset during the WRITE cycle -> mem_write = 0 that cycle, memory unchanged, all outputs at reset values at the next edge.
REQ-044 Issue 300 errored requests -> err_count saturates at 255.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Request/response bus between a client and mem_access_unit.
// The master issues requests and takes responses; the slave (the unit) serves them.
interface mem_access_unit_if #(
  parameter int DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [7:0]        req_base;
  logic [7:0]        req_offset;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_base, req_offset, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_base, req_offset, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: base+offset address generation, range
// check, one-cycle strobe to a combinational-read data memory, held response.
module mem_access_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_unit_if.slave  bus,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WRITE = 3'd2;
  localparam logic [2:0] ERR   = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  localparam logic [9:0] DEPTH_10 = 10'(DEPTH);

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;
  logic              valid_reg;
  logic [7:0]        count_reg;

  logic              accept;
  logic [9:0]        eff;
  logic              out_of_range;

  // 10 bits hold every base+offset sum (-128..382) without wrap; bit 9 is the sign.
  assign eff          = {2'b00, bus.req_base} + {{2{bus.req_offset[7]}}, bus.req_offset};
  assign out_of_range = eff[9] || (eff >= DEPTH_10);
  assign accept       = (state_reg == IDLE) && bus.req_valid;

  assign bus.req_ready  = (state_reg == IDLE);
  assign bus.resp_valid = valid_reg;
  assign bus.resp_rdata = rdata_reg;
  assign bus.resp_err   = err_reg;
  assign err_count      = count_reg;
  assign mem_addr       = addr_reg;
  assign mem_wdata      = wdata_reg;
  assign mem_read       = (state_reg == READ);
  // Reset asserted during the WRITE cycle must cancel the store immediately.
  assign mem_write      = (state_reg == WRITE) && !reset;

  // Next-state selection: route accepted requests by range and type.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          if (out_of_range)    state_next = ERR;
          else if (bus.req_we) state_next = WRITE;
          else                 state_next = READ;
        end
      end
      READ, WRITE, ERR: state_next = RESP;
      RESP: if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, latched request, response fields and saturating error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      valid_reg <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg  <= eff[ADDR_W-1:0];
        wdata_reg <= bus.req_wdata;
        // Stale fields from the previous response must not leak into this one.
        rdata_reg <= '0;
        err_reg   <= 1'b0;
      end
      case (state_reg)
        READ: begin
          rdata_reg <= mem_rdata;
          valid_reg <= 1'b1;
        end
        WRITE: valid_reg <= 1'b1;
        ERR: begin
          err_reg   <= 1'b1;
          valid_reg <= 1'b1;
          if (count_reg != 8'hFF) count_reg <= count_reg + 8'd1;
        end
        RESP: if (bus.resp_ready) valid_reg <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a transaction-level reference model.
module tb_mem_access_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_unit_if #(.DATA_W(16)) bus();

  logic [7:0]  err_count;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;

  mem_access_unit #(.DATA_W(16), .ADDR_W(6), .DEPTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .err_count (err_count),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  // Environment memory (combinational read) and strobe counters.
  logic [15:0] mem     [64];
  logic [15:0] ref_mem [64];
  int rd_cnt = 0;
  int wr_cnt = 0;
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)  rd_cnt <= rd_cnt + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
  end

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [5:0] exp_addr = '0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle invariants: strobes exclusive, and any strobe targets the expected address.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("strobe_mutex", 32'(mem_read && mem_write), 32'd0);
      if (mem_read || mem_write) chk("strobe_addr", 32'(mem_addr), 32'(exp_addr));
    end
  end

  task automatic check_reset_values();
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_err",   bus.resp_err, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_err_count",  err_count, 0);
    chk("rst_mem_addr",   mem_addr, 0);
    chk("rst_mem_wdata",  mem_wdata, 0);
    chk("rst_mem_read",   mem_read, 0);
    chk("rst_mem_write",  mem_write, 0);
    chk("rst_req_ready",  bus.req_ready, 1);
  endtask

  // One complete transaction, entered and left at a falling edge.
  task automatic do_req(input logic we, input logic [7:0] base, input logic [7:0] off,
                        input logic [15:0] wdata, input int hold,
                        output logic [15:0] got_rdata, output logic got_err);
    int eff;
    int rd0;
    int wr0;
    int waited;
    logic exp_err;
    logic [15:0] exp_rdata;
    logic [15:0] s_rdata;
    logic s_err;
    eff = int'(base) + int'($signed(off));
    exp_err = (eff < 0) || (eff >= 64);
    exp_rdata = 16'h0;
    if (!exp_err && !we) exp_rdata = ref_mem[eff];
    exp_addr = exp_err ? 6'd0 : eff[5:0];
    rd0 = rd_cnt;
    wr0 = wr_cnt;

    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_base = base;
    bus.req_offset = off; bus.req_wdata = wdata;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    chk("busy_no_ready", bus.req_ready, 0);
    chk("resp_early", bus.resp_valid, 0);
    @(posedge clk); @(negedge clk);
    chk("resp_latency", bus.resp_valid, 1);
    waited = 0;
    while (!bus.resp_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    s_rdata = bus.resp_rdata;
    s_err   = bus.resp_err;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_base = 8'd1;
      bus.req_offset = 8'd0; bus.req_wdata = 16'hDEAD;
      @(posedge clk); @(negedge clk);
      chk("hold_valid", bus.resp_valid, 1);
      chk("hold_rdata", bus.resp_rdata, s_rdata);
      chk("hold_err",   bus.resp_err, s_err);
      chk("hold_ready", bus.req_ready, 0);
    end
    bus.req_valid = 1'b0;

    if (!exp_err && we) ref_mem[eff] = wdata;
    if (exp_err) exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    chk("resp_err",   s_err, exp_err);
    chk("resp_rdata", s_rdata, exp_rdata);
    chk("err_count",  err_count, exp_cnt);
    chk("read_strobes",  rd_cnt - rd0, (!exp_err && !we) ? 1 : 0);
    chk("write_strobes", wr_cnt - wr0, (!exp_err && we) ? 1 : 0);
    if (!exp_err) chk("mem_content", mem[eff], ref_mem[eff]);

    bus.resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("resp_taken", bus.resp_valid, 0);
    $display("txn we=%0d base=%0d off=%0d eff=%0d err=%0d rdata=%h err_count=%0d",
             we, base, $signed(off), eff, s_err, s_rdata, err_count);
    got_rdata = s_rdata;
    got_err   = s_err;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r;
    logic e;
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 16'h1000 + 16'(i);
      ref_mem[i] = 16'h1000 + 16'(i);
    end
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_base = '0;
    bus.req_offset = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Store 0xBEEF to 10+5, then read it back.
    do_req(1'b1, 8'd10, 8'd5, 16'hBEEF, 0, r, e);
    chk("store15_err", e, 0);
    do_req(1'b0, 8'd15, 8'd0, 16'h0, 0, r, e);
    chk("load15_lit", r, 16'hBEEF);
    // Negative offset down to address 0.
    do_req(1'b0, 8'd3, 8'hFD, 16'h0, 0, r, e);
    chk("load0_lit", r, 16'h1000);
    // Boundaries.
    do_req(1'b0, 8'd63, 8'd0, 16'h0, 0, r, e);
    chk("load63_lit", r, 16'h103F);
    do_req(1'b0, 8'd60, 8'd4, 16'h0, 0, r, e);
    chk("oor64_err_lit", e, 1);
    chk("oor64_cnt_lit", err_count, 1);
    do_req(1'b1, 8'd0, 8'hFF, 16'h7777, 0, r, e);
    chk("neg1_err_lit", e, 1);
    chk("neg1_cnt_lit", err_count, 2);
    do_req(1'b1, 8'd200, 8'h80, 16'h3333, 0, r, e);
    chk("sum72_err_lit", e, 1);
    do_req(1'b1, 8'd100, 8'h9C, 16'h5A5A, 0, r, e);
    chk("sum0_err_lit", e, 0);
    do_req(1'b0, 8'd0, 8'd0, 16'h0, 0, r, e);
    chk("load0b_lit", r, 16'h5A5A);
    // Stalled consumer with ignored requests.
    do_req(1'b0, 8'd15, 8'd0, 16'h0, 5, r, e);
    chk("hold_load_lit", r, 16'hBEEF);

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) do_req(1'b0, 8'd60, 8'd4, 16'h0, 0, r, e);
      else            do_req(1'b1, 8'd0, 8'hFF, 16'h1, 0, r, e);
    end
    chk("sat_cnt_lit", err_count, 255);

    // Reset during the WRITE cycle cancels the store and drops the response.
    exp_addr = 6'd20;
    chk("pre_rst_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_base = 8'd20;
    bus.req_offset = 8'd0; bus.req_wdata = 16'h1234;
    @(posedge clk); @(negedge clk);
    bus.req_valid = 1'b0;
    chk("in_write", mem_write, 1);
    reset = 1'b1;
    #1;
    chk("write_gated", mem_write, 0);
    @(posedge clk); @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    exp_cnt = 0;
    chk("mem20_unchanged_lit", mem[20], 16'h1014);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale_resp", bus.resp_valid, 0);
    end
    do_req(1'b0, 8'd20, 8'd0, 16'h0, 0, r, e);
    chk("post_rst_load_lit", r, 16'h1014);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
